// File: rtl/div_unit_pkg.sv
// Shared widths, FSM encoding and sign helper for the EX-stage divider.
package div_unit_pkg;

  localparam int unsigned REG_BUS        = 32;
  localparam int unsigned DIV_RESULT_BUS = 64;
  localparam int unsigned DIV_CNT_BUS    = 5;

  localparam logic ENABLED  = 1'b1;
  localparam logic DISABLED = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE = 2'b00,
    DIV_ON   = 2'b01,
    DIV_END  = 2'b10
  } div_state_e;

  function automatic logic [REG_BUS-1:0] neg_if(input logic neg, input logic [REG_BUS-1:0] v);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring division iteration on the 65-bit {rem[32:0], quo[31:0]} register.
module div_unit_step
  import div_unit_pkg::*;
(
  input  logic [2*REG_BUS:0]   work_i,
  input  logic [REG_BUS-1:0]   divisor_i,
  output logic [2*REG_BUS:0]   work_o
);

  logic [REG_BUS+1:0] diff;

  // work_i[64:31] is the partial remainder after the left shift; bit 33 of diff is the borrow.
  always_comb begin
    diff   = work_i[2*REG_BUS:REG_BUS-1] - {2'b00, divisor_i};
    work_o = {work_i[2*REG_BUS-1:0], 1'b0};
    if (!diff[REG_BUS+1]) begin
      work_o = {diff[REG_BUS:0], work_i[REG_BUS-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV/DIVU/REM/REMU) with EX stall request.
// Optional macro DIV_ZERO_FAST_EN: zero divisor completes in one cycle.
module div_unit
  import div_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DIV_RESULT_BUS-1:0] result_o,
  output logic                      ready_o,
  output logic                      stallreq_o
);

`ifdef DIV_ZERO_FAST_EN
  localparam logic ZERO_FAST = ENABLED;
`else
  localparam logic ZERO_FAST = DISABLED;
`endif

  div_state_e             state, next_state;
  logic [DIV_CNT_BUS-1:0] cnt;
  logic [2*REG_BUS:0]     work, step_out;
  logic [REG_BUS-1:0]     divisor_r;
  logic                   quo_neg, rem_neg, zero_div;

  logic                   dvd_neg, dvs_neg, div_zero, accept;
  logic [REG_BUS-1:0]     abs_dvd, abs_dvs, quo, rem;

  assign dvd_neg  = signed_div_i & opdata1_i[REG_BUS-1];
  assign dvs_neg  = signed_div_i & opdata2_i[REG_BUS-1];
  assign abs_dvd  = neg_if(dvd_neg, opdata1_i);
  assign abs_dvs  = neg_if(dvs_neg, opdata2_i);
  assign div_zero = (opdata2_i == '0);
  assign accept   = (state == DIV_FREE) && start_i && !annul_i;

  div_unit_step u_step (
    .work_i    (work),
    .divisor_i (divisor_r),
    .work_o    (step_out)
  );

  always_comb begin
    next_state = state;
    case (state)
      DIV_FREE: if (accept) next_state = (ZERO_FAST && div_zero) ? DIV_END : DIV_ON;
      DIV_ON: begin
        if (annul_i)         next_state = DIV_FREE;
        else if (cnt == '1)  next_state = DIV_END;
      end
      DIV_END:  next_state = DIV_FREE;
      default:  next_state = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= DIV_FREE;
      cnt       <= '0;
      work      <= '0;
      divisor_r <= '0;
      quo_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      zero_div  <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        cnt       <= '0;
        divisor_r <= abs_dvs;
        quo_neg   <= dvd_neg ^ dvs_neg;
        rem_neg   <= dvd_neg;
        zero_div  <= div_zero;
        // Fast path parks |dividend| in the remainder field so DIV_END's sign fix restores it.
        work      <= (ZERO_FAST && div_zero) ? {1'b0, abs_dvd, {REG_BUS{1'b0}}}
                                             : {{(REG_BUS+1){1'b0}}, abs_dvd};
      end else if (state == DIV_ON && !annul_i) begin
        work <= step_out;
        cnt  <= cnt + DIV_CNT_BUS'(1);
      end
    end
  end

  // A zero divisor leaves rem = |dividend| after 32 steps, so only the quotient needs overriding.
  always_comb begin
    quo = zero_div ? '1 : neg_if(quo_neg, work[REG_BUS-1:0]);
    rem = neg_if(rem_neg, work[2*REG_BUS-1:REG_BUS]);
  end

  assign ready_o    = (state == DIV_END);
  assign result_o   = ready_o ? {rem, quo} : '0;
  assign stallreq_o = start_i & ~ready_o;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: results, latency, stall, annul and reset.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int errors = 0;
  int checks = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one divide at a negedge (cycle 0) and follow it to the ready pulse.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_q,
                        input logic [31:0] exp_r, input int exp_lat);
    int  lat;
    bit  stall_ok;
    bit  got;
    lat = 0;
    got = 0;
    stall_ok = 1;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    #1;
    if (!stallreq_o) stall_ok = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        got = 1;
        lat = i;
      end else if (!stallreq_o) begin
        stall_ok = 0;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " stall busy"}, 64'(stall_ok), 64'd1);
    check({tag, " result"}, result_o, {exp_r, exp_q});
    check({tag, " stall ready"}, 64'(stallreq_o), 64'd0);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " after"}, {ready_o, result_o[62:0]}, 64'd0);
  endtask

  initial begin
    int pulses;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #12;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    do_div("u100/7",       1'b0, 32'd100,       32'd7,         32'h0000000E, 32'h00000002, 33);
    do_div("s-7/2",        1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    do_div("s7/-2",        1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD, 32'h00000001, 33);
    do_div("s-100/7",      1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2, 32'hFFFFFFFE, 33);
    do_div("s_ovf",        1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 32'h00000000, 33);
    do_div("uFFFF/1",      1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF, 32'h00000000, 33);
    do_div("uFFFF/16",     1'b0, 32'hFFFFFFFF,  32'h10,        32'h0FFFFFFF, 32'h0000000F, 33);
    do_div("u8000/FFFF",   1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h00000000, 32'h80000000, 33);
    do_div("s-5/0",        1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF, 32'hFFFFFFFB, ZERO_LAT);
    do_div("u87654321/0",  1'b0, 32'h87654321,  32'd0,         32'hFFFFFFFF, 32'h87654321, ZERO_LAT);

    // Annul coinciding with the start cycle: nothing may be accepted.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) pulses++;
    end
    check("annul start pulses", 64'(pulses), 64'd0);

    // Annul in cycle 10 of a running divide, then an immediate 9/3.
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ready_o) pulses++;
    end
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    if (ready_o) pulses++;
    check("annul mid pulses", 64'(pulses), 64'd0);
    do_div("u9/3 post-annul", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Reset asserted in cycle 15, then a fresh divide.
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b0;
    start_i = 1'b0;
    #1;
    check("rst mid ready", 64'(ready_o), 64'd0);
    check("rst mid result", result_o, 64'd0);
    check("rst mid stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_div("u100/7 post-rst", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 33);

    // Reset landing inside the ready pulse clears outputs without waiting for a clock.
    @(negedge clk);
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (33) @(posedge clk);
    #1;
    check("pre-rst ready", {ready_o, result_o[62:0]}, {1'b1, 63'd3});
    rst = 1'b0;
    start_i = 1'b0;
    #1;
    check("rst end outputs", {ready_o, result_o[62:0]}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_div("s7/-2 final", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
